// File: rtl/excp_int_ctrl.sv
// Exception / interrupt controller at the writeback stage.
// Synchronises the interrupt lines, optionally edge-latches hardware lines,
// picks one event (interrupt > exception > ERTN) on the committing
// instruction, and issues a one-cycle registered CSR-update and flush
// request. After a flush, a drain window ignores further commits.
module excp_int_ctrl #(
  parameter int          HWI_NUM       = 8,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [7:0]  HWI_EDGE_MASK = 8'h00,
  parameter int          DRAIN_CYCLES  = 2,
  parameter logic [5:0]  TLBR_ECODE    = 6'h3F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [HWI_NUM-1:0] hwi_in,
  input  logic               ti_in,
  input  logic               ipi_in,
  input  logic [HWI_NUM-1:0] hwi_clr,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic               commit_excp,
  input  logic               commit_ertn,
  input  logic [5:0]         commit_ecode,
  input  logic [8:0]         commit_esubcode,
  input  logic               commit_badv_valid,
  input  logic [31:0]        commit_badv,
  input  logic [1:0]         crmd_plv,
  input  logic               crmd_ie,
  input  logic [1:0]         prmd_pplv,
  input  logic               prmd_pie,
  input  logic [12:0]        ecfg_lie,
  input  logic [1:0]         estat_swi,
  input  logic [31:0]        era,
  input  logic [31:0]        eentry,
  input  logic [31:0]        tlbrentry,
  output logic [10:0]        estat_is_hw,
  output logic               int_pending,
  output logic               flush_valid,
  output logic [31:0]        flush_pc,
  output logic               csr_we,
  output logic [1:0]         wr_crmd_plv,
  output logic               wr_crmd_ie,
  output logic [1:0]         wr_prmd_pplv,
  output logic               wr_prmd_pie,
  output logic [31:0]        wr_era,
  output logic [5:0]         wr_ecode,
  output logic [8:0]         wr_esubcode,
  output logic               wr_ecode_we,
  output logic [31:0]        wr_badv,
  output logic               wr_badv_we,
  output logic               busy
);

  // Lines carried through the synchroniser: {ipi, ti, hwi}
  localparam int NLINES = HWI_NUM + 2;

  // Counter only has to hold 1..DRAIN_CYCLES
  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_MAX = CW'(DRAIN_CYCLES);

  localparam logic [HWI_NUM-1:0] EDGE_MASK = HWI_EDGE_MASK[HWI_NUM-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_INT,
    EV_EXCP,
    EV_ERTN
  } event_t;

  logic [NLINES-1:0]  sync_q [SYNC_STAGES];
  logic [HWI_NUM-1:0] hwi_sync;
  logic               ti_sync;
  logic               ipi_sync;
  logic [HWI_NUM-1:0] hwi_prev;
  logic [HWI_NUM-1:0] hwi_pend;
  logic [HWI_NUM-1:0] hwi_rise;
  logic [HWI_NUM-1:0] hwi_pend_nxt;
  logic [HWI_NUM-1:0] hwi_eff;
  logic [7:0]         hwi_pad;
  logic [12:0]        int_vec;
  state_t             state;
  logic [CW-1:0]      drain_cnt;
  event_t             ev;

  assign hwi_sync = sync_q[SYNC_STAGES-1][HWI_NUM-1:0];
  assign ti_sync  = sync_q[SYNC_STAGES-1][HWI_NUM];
  assign ipi_sync = sync_q[SYNC_STAGES-1][HWI_NUM+1];

  // Multi-flop synchroniser chain for every asynchronous interrupt line
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {ipi_in, ti_in, hwi_in};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Edge detection and pending update; a new edge beats a simultaneous clear
  always_comb begin
    hwi_rise     = hwi_sync & ~hwi_prev & EDGE_MASK;
    hwi_pend_nxt = EDGE_MASK & (hwi_rise | (hwi_pend & ~hwi_clr));
    hwi_eff      = (EDGE_MASK & hwi_pend) | (~EDGE_MASK & hwi_sync);
  end

  // Edge-mode pending bits and the previous synchronised value
  always_ff @(posedge clk) begin
    if (rst) begin
      hwi_prev <= '0;
      hwi_pend <= '0;
    end else begin
      hwi_prev <= hwi_sync;
      hwi_pend <= hwi_pend_nxt;
    end
  end

  // Assemble the 13-bit interrupt vector; hwi lines above HWI_NUM read 0
  always_comb begin
    hwi_pad = '0;
    for (int i = 0; i < HWI_NUM; i++) hwi_pad[i] = hwi_eff[i];
    int_vec     = {ipi_sync, ti_sync, 1'b0, hwi_pad, estat_swi};
    int_pending = |(int_vec & ecfg_lie);
  end

  // Registered copy of the hardware part of ESTAT.IS
  always_ff @(posedge clk) begin
    if (rst) estat_is_hw <= '0;
    else     estat_is_hw <= int_vec[12:2];
  end

  // Event arbitration on the committing instruction
  always_comb begin
    ev = EV_NONE;
    if (commit_valid) begin
      if (int_pending && crmd_ie) ev = EV_INT;
      else if (commit_excp)       ev = EV_EXCP;
      else if (commit_ertn)       ev = EV_ERTN;
    end
  end

  assign busy = (state != S_IDLE);

  // Control FSM with one-cycle registered CSR-update and flush outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      drain_cnt    <= '0;
      flush_valid  <= 1'b0;
      flush_pc     <= '0;
      csr_we       <= 1'b0;
      wr_crmd_plv  <= '0;
      wr_crmd_ie   <= 1'b0;
      wr_prmd_pplv <= '0;
      wr_prmd_pie  <= 1'b0;
      wr_era       <= '0;
      wr_ecode     <= '0;
      wr_esubcode  <= '0;
      wr_ecode_we  <= 1'b0;
      wr_badv      <= '0;
      wr_badv_we   <= 1'b0;
    end else begin
      flush_valid  <= 1'b0;
      flush_pc     <= '0;
      csr_we       <= 1'b0;
      wr_crmd_plv  <= '0;
      wr_crmd_ie   <= 1'b0;
      wr_prmd_pplv <= '0;
      wr_prmd_pie  <= 1'b0;
      wr_era       <= '0;
      wr_ecode     <= '0;
      wr_esubcode  <= '0;
      wr_ecode_we  <= 1'b0;
      wr_badv      <= '0;
      wr_badv_we   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ev != EV_NONE) begin
            state       <= S_FLUSH;
            flush_valid <= 1'b1;
            csr_we      <= 1'b1;
          end
          case (ev)
            EV_INT: begin
              wr_crmd_plv  <= 2'd0;
              wr_crmd_ie   <= 1'b0;
              wr_prmd_pplv <= crmd_plv;
              wr_prmd_pie  <= crmd_ie;
              wr_era       <= commit_pc;
              wr_ecode     <= 6'd0;
              wr_esubcode  <= 9'd0;
              wr_ecode_we  <= 1'b1;
              flush_pc     <= eentry;
            end
            EV_EXCP: begin
              wr_crmd_plv  <= 2'd0;
              wr_crmd_ie   <= 1'b0;
              wr_prmd_pplv <= crmd_plv;
              wr_prmd_pie  <= crmd_ie;
              wr_era       <= commit_pc;
              wr_ecode     <= commit_ecode;
              wr_esubcode  <= commit_esubcode;
              wr_ecode_we  <= 1'b1;
              wr_badv      <= commit_badv_valid ? commit_badv : 32'd0;
              wr_badv_we   <= commit_badv_valid;
              flush_pc     <= (commit_ecode == TLBR_ECODE) ? tlbrentry : eentry;
            end
            EV_ERTN: begin
              wr_crmd_plv  <= prmd_pplv;
              wr_crmd_ie   <= prmd_pie;
              wr_prmd_pplv <= prmd_pplv;
              wr_prmd_pie  <= prmd_pie;
              wr_era       <= era;
              flush_pc     <= era;
            end
            default: ;
          endcase
        end
        S_FLUSH: begin
          if (DRAIN_CYCLES == 0) begin
            state <= S_IDLE;
          end else begin
            state     <= S_DRAIN;
            drain_cnt <= CW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt >= DRAIN_MAX) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          drain_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_int_ctrl.sv
// Directed self-checking bench for excp_int_ctrl: exception, TLBR refill,
// ERTN, level and edge interrupts, drain window and reset during drain.
module tb_excp_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hwi_in;
  logic        ti_in;
  logic        ipi_in;
  logic [7:0]  hwi_clr;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_excp;
  logic        commit_ertn;
  logic [5:0]  commit_ecode;
  logic [8:0]  commit_esubcode;
  logic        commit_badv_valid;
  logic [31:0] commit_badv;
  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  estat_swi;
  logic [31:0] era;
  logic [31:0] eentry;
  logic [31:0] tlbrentry;
  logic [10:0] estat_is_hw;
  logic        int_pending;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        csr_we;
  logic [1:0]  wr_crmd_plv;
  logic        wr_crmd_ie;
  logic [1:0]  wr_prmd_pplv;
  logic        wr_prmd_pie;
  logic [31:0] wr_era;
  logic [5:0]  wr_ecode;
  logic [8:0]  wr_esubcode;
  logic        wr_ecode_we;
  logic [31:0] wr_badv;
  logic        wr_badv_we;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  excp_int_ctrl #(
    .HWI_NUM      (8),
    .SYNC_STAGES  (2),
    .HWI_EDGE_MASK(8'h01),
    .DRAIN_CYCLES (2),
    .TLBR_ECODE   (6'h3F)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .hwi_in           (hwi_in),
    .ti_in            (ti_in),
    .ipi_in           (ipi_in),
    .hwi_clr          (hwi_clr),
    .commit_valid     (commit_valid),
    .commit_pc        (commit_pc),
    .commit_excp      (commit_excp),
    .commit_ertn      (commit_ertn),
    .commit_ecode     (commit_ecode),
    .commit_esubcode  (commit_esubcode),
    .commit_badv_valid(commit_badv_valid),
    .commit_badv      (commit_badv),
    .crmd_plv         (crmd_plv),
    .crmd_ie          (crmd_ie),
    .prmd_pplv        (prmd_pplv),
    .prmd_pie         (prmd_pie),
    .ecfg_lie         (ecfg_lie),
    .estat_swi        (estat_swi),
    .era              (era),
    .eentry           (eentry),
    .tlbrentry        (tlbrentry),
    .estat_is_hw      (estat_is_hw),
    .int_pending      (int_pending),
    .flush_valid      (flush_valid),
    .flush_pc         (flush_pc),
    .csr_we           (csr_we),
    .wr_crmd_plv      (wr_crmd_plv),
    .wr_crmd_ie       (wr_crmd_ie),
    .wr_prmd_pplv     (wr_prmd_pplv),
    .wr_prmd_pie      (wr_prmd_pie),
    .wr_era           (wr_era),
    .wr_ecode         (wr_ecode),
    .wr_esubcode      (wr_esubcode),
    .wr_ecode_we      (wr_ecode_we),
    .wr_badv          (wr_badv),
    .wr_badv_we       (wr_badv_we),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the commit-stage inputs for the coming cycle
  task automatic applyStimulus(input logic v, input logic ex, input logic er,
                               input logic [5:0] ec, input logic [8:0] esc,
                               input logic [31:0] pc, input logic bv,
                               input logic [31:0] ba);
    commit_valid      = v;
    commit_excp       = ex;
    commit_ertn       = er;
    commit_ecode      = ec;
    commit_esubcode   = esc;
    commit_pc         = pc;
    commit_badv_valid = bv;
    commit_badv       = ba;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Bounded wait for the controller to return to IDLE
  task automatic waitIdle();
    for (int i = 0; i < 10 && busy; i++) step();
    checkOutput("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    hwi_in    = '0;
    ti_in     = 1'b0;
    ipi_in    = 1'b0;
    hwi_clr   = '0;
    crmd_plv  = 2'd3;
    crmd_ie   = 1'b1;
    prmd_pplv = 2'd3;
    prmd_pie  = 1'b1;
    ecfg_lie  = '0;
    estat_swi = '0;
    era       = 32'h1C000200;
    eentry    = 32'h1C008000;
    tlbrentry = 32'h1C00F000;
    applyStimulus(0, 0, 0, 6'h00, 9'h000, 32'h0, 0, 32'h0);
    $display("[TB] start");

    // Reset state
    step(); step(); step();
    checkOutput("rst_flush_valid", {31'd0, flush_valid}, 32'd0);
    checkOutput("rst_csr_we", {31'd0, csr_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_flush_pc", flush_pc, 32'd0);
    checkOutput("rst_estat_is_hw", {21'd0, estat_is_hw}, 32'd0);
    checkOutput("rst_int_pending", {31'd0, int_pending}, 32'd0);
    rst = 1'b0;
    step();

    // Plain exception, commit held through the drain window
    applyStimulus(1, 1, 0, 6'h0B, 9'h000, 32'h1C000100, 0, 32'h0);
    step();
    checkOutput("exc_flush_valid", {31'd0, flush_valid}, 32'd1);
    checkOutput("exc_csr_we", {31'd0, csr_we}, 32'd1);
    checkOutput("exc_flush_pc", flush_pc, 32'h1C008000);
    checkOutput("exc_era", wr_era, 32'h1C000100);
    checkOutput("exc_ecode", {26'd0, wr_ecode}, 32'h0B);
    checkOutput("exc_ecode_we", {31'd0, wr_ecode_we}, 32'd1);
    checkOutput("exc_plv", {30'd0, wr_crmd_plv}, 32'd0);
    checkOutput("exc_ie", {31'd0, wr_crmd_ie}, 32'd0);
    checkOutput("exc_pplv", {30'd0, wr_prmd_pplv}, 32'd3);
    checkOutput("exc_pie", {31'd0, wr_prmd_pie}, 32'd1);
    checkOutput("exc_badv_we", {31'd0, wr_badv_we}, 32'd0);
    checkOutput("exc_busy", {31'd0, busy}, 32'd1);
    step();
    checkOutput("drain1_flush", {31'd0, flush_valid}, 32'd0);
    checkOutput("drain1_era_zero", wr_era, 32'd0);
    checkOutput("drain1_busy", {31'd0, busy}, 32'd1);
    step();
    checkOutput("drain2_flush", {31'd0, flush_valid}, 32'd0);
    checkOutput("drain2_busy", {31'd0, busy}, 32'd1);
    step();
    checkOutput("drain3_flush", {31'd0, flush_valid}, 32'd0);
    checkOutput("drain3_busy", {31'd0, busy}, 32'd0);
    step();
    checkOutput("refire_flush", {31'd0, flush_valid}, 32'd1);
    applyStimulus(0, 0, 0, 6'h00, 9'h000, 32'h0, 0, 32'h0);
    waitIdle();

    // TLB refill exception with bad virtual address
    applyStimulus(1, 1, 0, 6'h3F, 9'h001, 32'h1C000300, 1, 32'hDEAD0000);
    step();
    checkOutput("tlbr_flush_pc", flush_pc, 32'h1C00F000);
    checkOutput("tlbr_badv_we", {31'd0, wr_badv_we}, 32'd1);
    checkOutput("tlbr_badv", wr_badv, 32'hDEAD0000);
    checkOutput("tlbr_ecode", {26'd0, wr_ecode}, 32'h3F);
    checkOutput("tlbr_esubcode", {23'd0, wr_esubcode}, 32'h001);
    applyStimulus(0, 0, 0, 6'h00, 9'h000, 32'h0, 0, 32'h0);
    step();
    checkOutput("tlbr_after_badv_we", {31'd0, wr_badv_we}, 32'd0);
    checkOutput("tlbr_after_badv", wr_badv, 32'd0);
    checkOutput("tlbr_after_csr_we", {31'd0, csr_we}, 32'd0);
    waitIdle();

    // ERTN restores PLV/IE from PRMD and returns to ERA
    crmd_plv = 2'd0;
    crmd_ie  = 1'b0;
    applyStimulus(1, 0, 1, 6'h00, 9'h000, 32'h1C000400, 0, 32'h0);
    step();
    checkOutput("ertn_flush_valid", {31'd0, flush_valid}, 32'd1);
    checkOutput("ertn_flush_pc", flush_pc, 32'h1C000200);
    checkOutput("ertn_plv", {30'd0, wr_crmd_plv}, 32'd3);
    checkOutput("ertn_ie", {31'd0, wr_crmd_ie}, 32'd1);
    checkOutput("ertn_ecode_we", {31'd0, wr_ecode_we}, 32'd0);
    checkOutput("ertn_era", wr_era, 32'h1C000200);
    checkOutput("ertn_pplv", {30'd0, wr_prmd_pplv}, 32'd3);
    applyStimulus(0, 0, 0, 6'h00, 9'h000, 32'h0, 0, 32'h0);
    waitIdle();

    // Level hwi[3]; interrupt beats a simultaneous exception
    crmd_plv = 2'd2;
    crmd_ie  = 1'b1;
    ecfg_lie = 13'h0020;
    hwi_in   = 8'h08;
    step();
    checkOutput("lvl_pend_1cyc", {31'd0, int_pending}, 32'd0);
    step();
    checkOutput("lvl_pend_2cyc", {31'd0, int_pending}, 32'd1);
    applyStimulus(1, 1, 0, 6'h0B, 9'h005, 32'h1C000500, 0, 32'h0);
    step();
    checkOutput("int_flush_valid", {31'd0, flush_valid}, 32'd1);
    checkOutput("int_flush_pc", flush_pc, 32'h1C008000);
    checkOutput("int_ecode", {26'd0, wr_ecode}, 32'd0);
    checkOutput("int_esubcode", {23'd0, wr_esubcode}, 32'd0);
    checkOutput("int_ecode_we", {31'd0, wr_ecode_we}, 32'd1);
    checkOutput("int_era", wr_era, 32'h1C000500);
    checkOutput("int_pplv", {30'd0, wr_prmd_pplv}, 32'd2);
    checkOutput("int_pie", {31'd0, wr_prmd_pie}, 32'd1);
    checkOutput("int_ie", {31'd0, wr_crmd_ie}, 32'd0);
    checkOutput("int_estat_is_hw", {21'd0, estat_is_hw}, 32'h008);
    applyStimulus(0, 0, 0, 6'h00, 9'h000, 32'h0, 0, 32'h0);
    hwi_in = 8'h00;
    step();
    checkOutput("lvl_drop_1cyc", {31'd0, int_pending}, 32'd1);
    step();
    checkOutput("lvl_drop_2cyc", {31'd0, int_pending}, 32'd0);
    waitIdle();

    // Edge hwi[0]: one-cycle pulse latches, clear drops it
    crmd_ie  = 1'b0;
    ecfg_lie = 13'h0004;
    hwi_in   = 8'h01;
    step();
    hwi_in = 8'h00;
    step();
    checkOutput("edge_pend_2cyc", {31'd0, int_pending}, 32'd0);
    step();
    checkOutput("edge_pend_3cyc", {31'd0, int_pending}, 32'd1);
    step();
    checkOutput("edge_estat_is_hw", {21'd0, estat_is_hw}, 32'h001);
    step();
    checkOutput("edge_hold", {31'd0, int_pending}, 32'd1);
    hwi_clr = 8'h01;
    step();
    hwi_clr = 8'h00;
    checkOutput("edge_clr", {31'd0, int_pending}, 32'd0);

    // New edge coinciding with a clear keeps the pending bit
    hwi_in = 8'h01;
    step();
    hwi_in = 8'h00;
    step();
    hwi_clr = 8'h01;
    step();
    hwi_clr = 8'h00;
    checkOutput("edge_set_beats_clr", {31'd0, int_pending}, 32'd1);
    hwi_clr = 8'h01;
    step();
    hwi_clr = 8'h00;
    checkOutput("edge_clr2", {31'd0, int_pending}, 32'd0);

    // Timer line lands in IS bit 11
    ecfg_lie = 13'h0800;
    ti_in    = 1'b1;
    step();
    step();
    checkOutput("ti_pending", {31'd0, int_pending}, 32'd1);
    step();
    checkOutput("ti_estat_is_hw", {21'd0, estat_is_hw}, 32'h200);
    ti_in = 1'b0;
    step(); step(); step();
    checkOutput("ti_cleared", {21'd0, estat_is_hw}, 32'h000);

    // Reset while draining aborts straight to IDLE
    ecfg_lie = '0;
    applyStimulus(1, 1, 0, 6'h0B, 9'h000, 32'h1C000600, 0, 32'h0);
    step();
    checkOutput("rstd_flush", {31'd0, flush_valid}, 32'd1);
    applyStimulus(0, 0, 0, 6'h00, 9'h000, 32'h0, 0, 32'h0);
    step();
    checkOutput("rstd_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rstd_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("rstd_flush_after", {31'd0, flush_valid}, 32'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/excp_int_ctrl.md
# excp_int_ctrl

Parametrised exception/interrupt controller at the writeback stage. Synchronises and optionally edge-latches hardware interrupt lines, arbitrates interrupt, exception and ERTN events on the committing instruction, and issues registered CSR-update and pipeline-flush requests. A post-flush drain window blocks further events. Generalises the single-cycle combinational exception unit with configurable HWI count, synchroniser depth, per-line edge mode and sequential flush handling.

## Interface
Parameters:
- HWI_NUM, 8: hardware interrupt lines, 1..8; unused IS bits read 0
- SYNC_STAGES, 2: flops in each hwi/ti/ipi synchroniser, >=1
- HWI_EDGE_MASK, 8'h00: bit i set makes hwi[i] rising-edge latched, clear makes it level
- DRAIN_CYCLES, 2: cycles commits are ignored after a flush pulse, >=0
- TLBR_ECODE, 6'h3F: ecode selecting tlbrentry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hwi_in  in  HWI_NUM  async hardware interrupt lines
- ti_in, ipi_in  in  1 each  timer / inter-processor interrupt
- hwi_clr  in  HWI_NUM  one-cycle clear of latched edge pendings
- commit_valid  in  1  an instruction is at writeback this cycle
- commit_pc  in  32  its PC
- commit_excp, commit_ertn  in  1 each  exception / ERTN flags
- commit_ecode  in  6;  commit_esubcode  in  9
- commit_badv_valid  in  1;  commit_badv  in  32
- crmd_plv  in  2;  crmd_ie  in  1;  prmd_pplv  in  2;  prmd_pie  in  1
- ecfg_lie  in  13;  estat_swi  in  2;  era, eentry, tlbrentry  in  32 each
- estat_is_hw  out  11  registered IS[12:2] = {ipi, ti, 0, hwi padded to 8}
- int_pending  out  1  any enabled interrupt pending (ignores crmd_ie)
- flush_valid  out  1  one-cycle redirect pulse;  flush_pc  out  32
- csr_we  out  1  one-cycle strobe, coincident with flush_valid
- wr_crmd_plv  out  2;  wr_crmd_ie  out  1;  wr_prmd_pplv  out  2;  wr_prmd_pie  out  1
- wr_era  out  32;  wr_ecode  out  6;  wr_esubcode  out  9;  wr_ecode_we  out  1
- wr_badv  out  32;  wr_badv_we  out  1
- busy  out  1  state != IDLE

## Operation
- Synchronise hwi_in/ti_in/ipi_in through SYNC_STAGES flops.
- Level lines use the synchronised value directly.
- Edge lines set a pending bit on a synchronised 0->1; hwi_clr[i] clears it; set and clear in the same cycle leaves it set.
- int_vec[12:0] = {ipi, ti, 0, hwi_eff padded to 8, estat_swi}.
- int_pending = |(int_vec & ecfg_lie).
- estat_is_hw = int_vec[12:2], registered.
- FSM states IDLE, FLUSH, DRAIN.
- In IDLE with commit_valid: priority interrupt (int_pending & crmd_ie) > commit_excp > commit_ertn; otherwise stay IDLE.
- Interrupt: PLV 0, IE 0; PPLV/PIE <= crmd_plv/ie; ERA <= commit_pc; ecode 0, esubcode 0, wr_ecode_we 1; flush_pc <= eentry.
- Exception: as interrupt, but ecode/esubcode come from commit; flush_pc <= tlbrentry when ecode == TLBR_ECODE, else eentry. wr_badv_we = commit_badv_valid, wr_badv = commit_badv.
- ERTN: PLV <= prmd_pplv, IE <= prmd_pie; wr_ecode_we 0; flush_pc <= era. PRMD and ERA are rewritten with their current values.
- Any taken event moves IDLE->FLUSH. FLUSH lasts one cycle, then goes to DRAIN (or IDLE if DRAIN_CYCLES == 0).
- DRAIN counts DRAIN_CYCLES cycles, then returns to IDLE.
- In FLUSH and DRAIN, commit_valid is ignored entirely.
- Pending interrupts persist and are taken at the first commit back in IDLE.

## Timing
- An event decided in cycle T drives csr_we, flush_valid, flush_pc and all wr_* from registers in T+1, for exactly one cycle. All wr_* are 0 when csr_we is 0.
- Next event accepted no earlier than T+2+DRAIN_CYCLES.
- Interrupt line to int_pending latency: SYNC_STAGES cycles, plus 1 cycle for edge lines.
- Reset: all outputs 0, state IDLE, synchronisers/pendings/counter 0. rst during FLUSH or DRAIN aborts to IDLE with no pulse the next cycle.
- Interrupt and exception on the same commit: the interrupt wins, and the exception ecode is discarded.

## Test plan
- Exception: commit_excp, ecode 6'h0B, pc 0x1C000100, eentry 0x1C008000 -> T+1 single-cycle flush to 0x1C008000; era 0x1C000100; ecode 0x0B; plv 0; ie 0.
- TLBR: ecode 6'h3F, badv_valid, badv 0xDEAD0000, tlbrentry 0x1C00F000 -> flush_pc 0x1C00F000; wr_badv_we 1; wr_badv 0xDEAD0000.
- Level hwi[3] high, lie bit 5, ie 1 -> int_pending after 2 cycles; next commit flushes with ecode 0 and estat_is_hw[3] = 1. Lowering hwi[3] drops int_pending after 2 cycles.
- Edge hwi[0] (mask 8'h01) 1-cycle pulse -> pending holds; hwi_clr[0] clears it; simultaneous new edge and clr keeps it set.
- ERTN: prmd_pplv 3, pie 1, era 0x1C000200 -> flush to 0x1C000200; plv 3; ie 1; wr_ecode_we 0.
- Back-to-back commits during DRAIN (DRAIN_CYCLES=2) -> no second flush until the third cycle after the pulse; rst in DRAIN -> busy 0 next cycle.
